fft_acc_ram_loader: RTL

- Avalon-MM write master that sits directly upstream of the 8192x32 single-port on-chip instruction/sample RAM (13-bit word address, 4-bit byteenable).
- Accepts a byte stream (valid/ready), packs bytes little-endian into 32-bit words and writes them into the RAM starting at a given word address.
- After loading, reads the region back and checks a byte checksum, so the FFT program or data image can be loaded and verified without the CPU.

---
 rtl/fft_acc_ram_loader.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fft_acc_ram_loader.sv
// Streams bytes into a 32-bit word RAM (little-endian packing), then reads the
// region back and compares a byte checksum against the one taken on the way in.

module fft_acc_ram_loader_lane (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       ld,
  input  logic [7:0] din,
  input  logic       rb_en,
  input  logic [7:0] rb_byte,
  output logic [7:0] q,
  output logic [7:0] rb_q
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (clr)  q <= '0;
    else if (ld)   q <= din;
  end

  // Readback lanes outside the word's mask contribute nothing to the sum.
  assign rb_q = rb_en ? rb_byte : 8'h00;
endmodule

module fft_acc_ram_loader #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8192,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  byte_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reset_req,
  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  output logic              ram_clken,
  input  logic [31:0]       ram_readdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              verify_err,
  output logic [31:0]       checksum
);
  localparam int NUM_LANES = 4;
  localparam int NW_W      = CNT_W + 1;
  localparam int SUM_W     = ((NW_W > ADDR_W) ? NW_W : ADDR_W) + 1;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_FILL, S_WRITE, S_VERIFY} state_t;

  typedef struct packed {
    logic                 cs;
    logic                 we;
    logic [ADDR_W-1:0]    addr;
    logic [NUM_LANES-1:0] be;
  } ram_req_t;

  state_t                        state_q, state_d;
  ram_req_t                      req;
  logic [ADDR_W-1:0]             base_q, cur_q, vaddr_q;
  logic [CNT_W-1:0]              cnt_q, left_q;
  logic [NW_W-1:0]               nw_in, nw_q, vleft_q;
  logic [1:0]                    lane_q;
  logic [NUM_LANES-1:0]          wr_be_q, last_be_q, last_be_in, rd_mask_q;
  logic                          rd_vld_q, rd_last_q;
  logic [31:0]                   rb_sum_q, rb_add;
  logic [NUM_LANES-1:0][7:0]     word_q, rb_lane;
  logic                          accept, fire, wr_go, rd_issue, rd_take, range_err;

  assign accept    = (state_q == S_IDLE) && start;
  assign nw_in     = (NW_W'(byte_count) + NW_W'(3)) >> 2;
  assign range_err = (SUM_W'(base_q) + SUM_W'(nw_q)) > SUM_W'(DEPTH);

  always_comb begin
    unique case (byte_count[1:0])
      2'd1:    last_be_in = 4'b0001;
      2'd2:    last_be_in = 4'b0011;
      2'd3:    last_be_in = 4'b0111;
      default: last_be_in = 4'b1111;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    fft_acc_ram_loader_lane u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (wr_go || accept),
      .ld      (fire && (lane_q == 2'(i))),
      .din     (in_data),
      .rb_en   (rd_mask_q[i]),
      .rb_byte (ram_readdata[8*i +: 8]),
      .q       (word_q[i]),
      .rb_q    (rb_lane[i])
    );
  end

  always_comb begin
    rb_add = '0;
    for (int i = 0; i < NUM_LANES; i++) rb_add = rb_add + 32'(rb_lane[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    req      = '0;
    fire     = 1'b0;
    wr_go    = 1'b0;
    rd_issue = 1'b0;
    rd_take  = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_CHECK;
      S_CHECK: begin
        if (range_err || (cnt_q == '0)) state_d = S_IDLE;
        else                            state_d = S_FILL;
      end
      S_FILL: begin
        in_ready = 1'b1;
        fire     = in_valid;
        if (fire && ((lane_q == 2'd3) || (left_q == CNT_W'(1)))) state_d = S_WRITE;
      end
      S_WRITE: begin
        req.cs   = 1'b1;
        req.we   = 1'b1;
        req.addr = cur_q;
        req.be   = wr_be_q;
        // reset_req stalls the RAM clock, so the request is simply held.
        if (!reset_req) begin
          wr_go   = 1'b1;
          state_d = (left_q == '0) ? S_VERIFY : S_FILL;
        end
      end
      S_VERIFY: begin
        req.cs   = (vleft_q != '0);
        req.addr = vaddr_q;
        rd_issue = req.cs && !reset_req;
        rd_take  = rd_vld_q && !reset_req;
        if (rd_take && rd_last_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ram_chipselect = req.cs;
  assign ram_write      = req.we;
  assign ram_address    = req.addr;
  assign ram_byteenable = req.be;
  assign ram_writedata  = req.we ? word_q : 32'h0;
  assign ram_clken      = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      cur_q      <= '0;
      vaddr_q    <= '0;
      cnt_q      <= '0;
      left_q     <= '0;
      nw_q       <= '0;
      vleft_q    <= '0;
      lane_q     <= '0;
      wr_be_q    <= '0;
      last_be_q  <= '0;
      rd_mask_q  <= '0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      rb_sum_q   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      verify_err <= 1'b0;
      checksum   <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        base_q     <= start_addr;
        cur_q      <= start_addr;
        cnt_q      <= byte_count;
        left_q     <= byte_count;
        nw_q       <= nw_in;
        last_be_q  <= last_be_in;
        lane_q     <= '0;
        wr_be_q    <= '0;
        rb_sum_q   <= '0;
        error      <= 1'b0;
        verify_err <= 1'b0;
        checksum   <= '0;
        busy       <= 1'b1;
      end
      if (state_q == S_CHECK) begin
        if (range_err) begin
          error <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
        end else if (cnt_q == '0) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
      if (fire) begin
        checksum <= checksum + 32'(in_data);
        left_q   <= left_q - CNT_W'(1);
        lane_q   <= lane_q + 2'd1;
        wr_be_q  <= {wr_be_q[NUM_LANES-2:0], 1'b1};
      end
      if (wr_go) begin
        cur_q   <= cur_q + ADDR_W'(1);
        lane_q  <= '0;
        wr_be_q <= '0;
        if (left_q == '0) begin
          vaddr_q  <= base_q;
          vleft_q  <= nw_q;
          rd_vld_q <= 1'b0;
        end
      end
      if (rd_issue) begin
        vaddr_q   <= vaddr_q + ADDR_W'(1);
        vleft_q   <= vleft_q - NW_W'(1);
        rd_last_q <= (vleft_q == NW_W'(1));
        rd_mask_q <= (vleft_q == NW_W'(1)) ? last_be_q : 4'b1111;
      end
      if ((state_q == S_VERIFY) && !reset_req) rd_vld_q <= rd_issue;
      if (rd_take) begin
        rb_sum_q <= rb_sum_q + rb_add;
        if (rd_last_q) begin
          verify_err <= ((rb_sum_q + rb_add) != checksum);
          done       <= 1'b1;
          busy       <= 1'b0;
        end
      end
    end
  end
endmodule
